// File: rtl/led_cnt_mc_if.sv
// led_cnt_mc_if: configuration/status bundle for the multi-channel LED blinker.
// cfg_wren_i is a one-cycle write strobe with no back-pressure. The write is
// accepted on the clk100 edge where it is high. There is no ready signal,
// because the block can always take a write.
interface led_cnt_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]      cfg_ch_i;
    logic [CNT_W-1:0]     cfg_period_i;
    logic                 cfg_wren_i;
    logic [NUM_CH-1:0]    en_i;
    logic [NUM_CH-1:0]    int_clr_i;
    logic [NUM_CH-1:0]    led_o;
    logic [NUM_CH-1:0]    int_o;
    logic                 irq_o;
    logic [NUM_CH*32-1:0] edge_cnt_o;

    modport master (
        output cfg_ch_i, cfg_period_i, cfg_wren_i, en_i, int_clr_i,
        input  led_o, int_o, irq_o, edge_cnt_o
    );

    modport slave (
        input  cfg_ch_i, cfg_period_i, cfg_wren_i, en_i, int_clr_i,
        output led_o, int_o, irq_o, edge_cnt_o
    );
endinterface

// File: rtl/led_cnt_mc.sv
// led_cnt_mc: NUM_CH independent half-period LED counters. Each channel drives
// one LED, one sticky rising-edge interrupt flag and one 32-bit edge counter.
// The flags are ORed into a single registered irq_o.
// Optional feature macro LED_CNT_MC_STRETCH_EN: when it is defined, irq_o is
// held high for at least IRQ_MIN_CYC cycles each time it asserts.
// Simulation builds (SYNTHESIS undefined) scale DEF_PERIOD down by 100000.
// The scaled value is never allowed to drop below 15.
module led_cnt_mc #(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEF_PERIOD  = 32'h05F5_E0FF,
    parameter int               IRQ_MIN_CYC = 8
) (
    input logic         clk100,
    input logic         rst,
    led_cnt_mc_if.slave bus
);

`ifndef SYNTHESIS
    localparam logic [CNT_W-1:0] DEF_SCALED = DEF_PERIOD / CNT_W'(100000);
    localparam logic [CNT_W-1:0] DEF_EFF    = (DEF_SCALED < CNT_W'(15)) ? CNT_W'(15) : DEF_SCALED;
`else
    localparam logic [CNT_W-1:0] DEF_EFF    = DEF_PERIOD;
`endif

    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  eff_per  [NUM_CH];
    logic [31:0]       ecnt_q   [NUM_CH];
    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] led_d;
    logic [NUM_CH-1:0] int_q;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] rise;
    logic              irq_q;

    // Decode the channel write and pick the effective period. A zero period falls back to the default.
    // A write to a channel index >= NUM_CH matches no channel, so it is dropped.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            wr_hit[n]  = bus.cfg_wren_i && (int'(bus.cfg_ch_i) == n);
            eff_per[n] = (period_q[n] == '0) ? DEF_EFF : period_q[n];
        end
    end

    assign rise = led_q & ~led_d;

    // Per-channel counters, LEDs, sticky flags and edge counters.
    always_ff @(posedge clk100) begin
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                period_q[n] <= DEF_EFF;
                cnt_q[n]    <= '0;
                ecnt_q[n]   <= '0;
            end
            led_q <= '0;
            led_d <= '0;
            int_q <= '0;
        end else begin
            led_d <= led_q;
            for (int n = 0; n < NUM_CH; n++) begin
                // A configuration write overrides counting and restarts the channel dark.
                if (wr_hit[n]) begin
                    period_q[n] <= bus.cfg_period_i;
                    cnt_q[n]    <= '0;
                    led_q[n]    <= 1'b0;
                end else if (bus.en_i[n]) begin
                    if (cnt_q[n] == eff_per[n]) begin
                        cnt_q[n] <= '0;
                        led_q[n] <= ~led_q[n];
                    end else begin
                        cnt_q[n] <= cnt_q[n] + 1'b1;
                    end
                end else begin
                    cnt_q[n] <= '0;
                end
                // When a set and a clear arrive together, the set wins, so no edge is lost.
                if (rise[n]) begin
                    int_q[n] <= 1'b1;
                end else if (bus.int_clr_i[n]) begin
                    int_q[n] <= 1'b0;
                end
                if (bus.int_clr_i[n]) begin
                    ecnt_q[n] <= rise[n] ? 32'd1 : 32'd0;
                end else if (rise[n]) begin
                    ecnt_q[n] <= ecnt_q[n] + 32'd1;
                end
            end
        end
    end

`ifdef LED_CNT_MC_STRETCH_EN
    localparam int SW = (IRQ_MIN_CYC > 1) ? $clog2(IRQ_MIN_CYC) : 1;
    logic [SW-1:0] stretch_q;
    logic          irq_nx;

    assign irq_nx = (|int_q) || (stretch_q != '0);

    // Aggregate irq with a minimum high time. The counter is loaded when irq_o rises.
    always_ff @(posedge clk100) begin
        if (rst) begin
            irq_q     <= 1'b0;
            stretch_q <= '0;
        end else begin
            irq_q <= irq_nx;
            if (irq_nx && !irq_q) begin
                stretch_q <= SW'(IRQ_MIN_CYC - 1);
            end else if (stretch_q != '0) begin
                stretch_q <= stretch_q - 1'b1;
            end
        end
    end
`else
    // Aggregate irq: a registered OR of the per-channel flags.
    always_ff @(posedge clk100) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |int_q;
        end
    end
`endif

    assign bus.led_o = led_q;
    assign bus.int_o = int_q;
    assign bus.irq_o = irq_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ecnt
        assign bus.edge_cnt_o[32*g +: 32] = ecnt_q[g];
    end

endmodule

// File: tb/tb_led_cnt_mc.sv
// tb_led_cnt_mc: directed self-checking bench for led_cnt_mc. It uses three
// channels so that channel index 3 is an out-of-range write.
module tb_led_cnt_mc;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
`ifdef LED_CNT_MC_STRETCH_EN
    localparam int IRQ_W_EXP = 8;
`else
    localparam int IRQ_W_EXP = 3;
`endif

    logic clk100;
    logic rst;
    int   n_chk;
    int   n_err;

    led_cnt_mc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    led_cnt_mc #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (32'h05F5_E0FF),
        .IRQ_MIN_CYC(8)
    ) dut (
        .clk100(clk100),
        .rst   (rst),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drivers: all stimulus changes happen at the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cfg_wren_i = 1'b0;
        bus.en_i = '0;
        bus.int_clr_i = '0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input logic [31:0] per);
        bus.cfg_ch_i = 2'(ch);
        bus.cfg_period_i = per;
        bus.cfg_wren_i = 1'b1;
        step(1);
        bus.cfg_wren_i = 1'b0;
    endtask

    function automatic logic [31:0] ecnt(input int n);
        return bus.edge_cnt_o[32*n +: 32];
    endfunction

    initial begin
        int   hi;
        logic found;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.cfg_ch_i = '0;
        bus.cfg_period_i = '0;
        bus.cfg_wren_i = 1'b0;
        bus.en_i = '0;
        bus.int_clr_i = '0;
        step(2);

        // Test 1: reset values, then channel 0 with period 9 gives a 10-cycle half-period.
        do_reset();
        chk("rst_led", 32'(bus.led_o), 32'h0);
        chk("rst_int", 32'(bus.int_o), 32'h0);
        chk("rst_irq", 32'(bus.irq_o), 32'h0);
        chk("rst_ecnt", 32'(|bus.edge_cnt_o), 32'h0);
        cfg_write(0, 32'd9);
        bus.en_i = 3'b001;
        step(9);  chk("t1_led_e9", 32'(bus.led_o), 32'h0);
        step(1);  chk("t1_led_e10", 32'(bus.led_o), 32'h1);
        step(1);  chk("t1_int", 32'(bus.int_o), 32'h1);
                  chk("t1_irq_lag", 32'(bus.irq_o), 32'h0);
        step(1);  chk("t1_irq", 32'(bus.irq_o), 32'h1);
        step(8);  chk("t1_led_e20", 32'(bus.led_o), 32'h0);

        // Test 2: reset in mid-run, then channel 1 with period 4 for three LED periods.
        do_reset();
        chk("rst_mid_led", 32'(bus.led_o), 32'h0);
        chk("rst_mid_int", 32'(bus.int_o), 32'h0);
        chk("rst_mid_ecnt0", ecnt(0), 32'h0);
        cfg_write(1, 32'd4);
        bus.en_i = 3'b010;
        step(5);  chk("t2_led", 32'(bus.led_o), 32'h2);
                  chk("t2_int_lag", 32'(bus.int_o), 32'h0);
        step(1);  chk("t2_int", 32'(bus.int_o), 32'h2);
                  chk("t2_irq_lag", 32'(bus.irq_o), 32'h0);
        step(1);  chk("t2_irq", 32'(bus.irq_o), 32'h1);
        step(18); chk("t2_led_e25", 32'(bus.led_o), 32'h2);
                  chk("t2_ecnt_e25", ecnt(1), 32'd2);
        step(1);  chk("t2_ecnt", ecnt(1), 32'd3);

        // Test 3: a clear in the same cycle as a rise; the set wins. A clear alone resets the flag and count.
        do_reset();
        cfg_write(2, 32'd2);
        bus.en_i = 3'b100;
        step(3);  chk("t3_led", 32'(bus.led_o), 32'h4);
        bus.int_clr_i = 3'b100;
        step(1);  chk("t3_int_setwins", 32'(bus.int_o), 32'h4);
                  chk("t3_ecnt_one", ecnt(2), 32'd1);
        step(1);  chk("t3_int_clr", 32'(bus.int_o), 32'h0);
                  chk("t3_ecnt_clr", ecnt(2), 32'd0);
        bus.int_clr_i = '0;

        // Test 4: an out-of-range write is ignored. A period of 0 selects the default period (999 in simulation).
        do_reset();
        cfg_write(0, 32'd4);
        bus.en_i = 3'b001;
        step(5);  chk("t4_led_on", 32'(bus.led_o), 32'h1);
        bus.en_i = 3'b000;
        step(3);  chk("t4_led_hold", 32'(bus.led_o), 32'h1);
        cfg_write(3, 32'd1);
        chk("t4_oor_led", 32'(bus.led_o), 32'h1);
        bus.en_i = 3'b001;
        step(4);  chk("t4_oor_e4", 32'(bus.led_o), 32'h1);
        step(1);  chk("t4_oor_period", 32'(bus.led_o), 32'h0);
        step(5);  chk("t4_led_on2", 32'(bus.led_o), 32'h1);
        cfg_write(0, 32'd0);
        chk("t4_cfg_forces0", 32'(bus.led_o), 32'h0);
        step(999); chk("t4_def_e999", 32'(bus.led_o), 32'h0);
        step(1);   chk("t4_def_e1000", 32'(bus.led_o), 32'h1);

        // Test 5: disabling in mid-count restarts a full half-period on re-enable.
        do_reset();
        cfg_write(2, 32'd6);
        bus.en_i = 3'b100;
        step(3);
        bus.en_i = 3'b000;
        step(6);  chk("t5_led_held", 32'(bus.led_o), 32'h0);
        bus.en_i = 3'b100;
        step(6);  chk("t5_reen_e6", 32'(bus.led_o), 32'h0);
        step(1);  chk("t5_reen_e7", 32'(bus.led_o), 32'h4);

        // Test 6: rises on two channels in the same cycle are both captured.
        do_reset();
        cfg_write(0, 32'd3);
        cfg_write(1, 32'd3);
        bus.en_i = 3'b011;
        step(3);  chk("t6_led_pre", 32'(bus.led_o), 32'h0);
        step(1);  chk("t6_led", 32'(bus.led_o), 32'h3);
        step(1);  chk("t6_int", 32'(bus.int_o), 32'h3);
                  chk("t6_ecnt0", ecnt(0), 32'd1);
                  chk("t6_ecnt1", ecnt(1), 32'd1);

        // Test 7: irq_o high time when the flags are cleared two cycles after irq_o rises.
        do_reset();
        cfg_write(0, 32'd2);
        bus.en_i = 3'b001;
        step(3);  chk("t7_led", 32'(bus.led_o), 32'h1);
        bus.en_i = 3'b000;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            if (bus.irq_o) found = 1'b1;
        end
        chk("t7_irq_seen", 32'(found), 32'h1);
        hi = 1;
        step(1);
        hi += int'(bus.irq_o);
        bus.int_clr_i = 3'b111;
        step(1);
        hi += int'(bus.irq_o);
        bus.int_clr_i = 3'b000;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!bus.irq_o) break;
            hi++;
        end
        chk("t7_irq_width", 32'(hi), 32'(IRQ_W_EXP));
        chk("t7_int_clr", 32'(bus.int_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
